// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: opcode and state encodings, field widths.
package seq_pkg;

    localparam int PC_W      = 10;
    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 6;
    localparam int INSTR_W   = OPCODE_W + OPERAND_W;

    typedef enum logic [OPCODE_W-1:0] {
        OP_RESULT             = 4'd0,
        OP_SET_IMMEDIATE      = 4'd1,
        OP_LOAD               = 4'd2,
        OP_STORE              = 4'd3,
        OP_JUMP_BACK_OR_INIT  = 4'd4,
        OP_ADD                = 4'd5,
        OP_SUB                = 4'd6,
        OP_AND                = 4'd7,
        OP_OR                 = 4'd8,
        OP_JUMP_OR_INIT_FP    = 4'd9,
        OP_SKIP_IF_NOT_ONE    = 4'd10,
        OP_XOR                = 4'd11,
        OP_SHL                = 4'd12,
        OP_SHR                = 4'd13,
        OP_RETURN             = 4'd14,
        OP_ILLEGAL            = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_e;

    // Opcodes handed to the datapath; everything else is resolved inside the sequencer.
    function automatic logic is_exec_op(input opcode_e op);
        case (op)
            OP_JUMP_BACK_OR_INIT, OP_JUMP_OR_INIT_FP, OP_SKIP_IF_NOT_ONE,
            OP_RETURN, OP_ILLEGAL: is_exec_op = 1'b0;
            default:               is_exec_op = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/seq_next_pc.sv
// Combinational next-PC generator; all arithmetic wraps modulo 2**PC_W.
module seq_next_pc
    import seq_pkg::*;
(
    input  logic [PC_W-1:0]      pc,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [OPERAND_W-1:0] operand,
    input  logic                 flag,
    output logic [PC_W-1:0]      next_pc
);

    logic [PC_W-1:0] opd_ext;
    logic [PC_W-1:0] pc_inc;

    assign opd_ext = PC_W'(operand);
    assign pc_inc  = pc + PC_W'(1);

    always_comb begin
        next_pc = pc_inc;
        case (opcode_e'(opcode))
            OP_JUMP_BACK_OR_INIT: next_pc = pc - opd_ext;
            OP_JUMP_OR_INIT_FP:   next_pc = pc + opd_ext;
            OP_SKIP_IF_NOT_ONE:   next_pc = flag ? pc_inc : pc + PC_W'(2);
            OP_RETURN:            next_pc = pc;
            default:              next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer with handshaked instruction memory and datapath.
// Define SEQ_ILLEGAL_TRAP_EN to trap opcode 15 into HALT with a sticky illegal_op.
module instr_sequencer
    import seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [OPERAND_W-1:0] operand,
    output logic                 exec_valid,
    input  logic                 exec_done,
    input  logic                 flag,
    output logic                 halted,
    output logic                 illegal_op
);

    state_e          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;

    assign imem_addr = pc;

    seq_next_pc u_next_pc (
        .pc      (pc),
        .opcode  (opcode),
        .operand (operand),
        .flag    (flag),
        .next_pc (npc)
    );

`ifndef SEQ_ILLEGAL_TRAP_EN
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            opcode     <= '0;
            operand    <= '0;
            imem_req   <= 1'b0;
            exec_valid <= 1'b0;
            halted     <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_op <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc       <= '0;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        opcode   <= imem_data[INSTR_W-1:OPERAND_W];
                        operand  <= imem_data[OPERAND_W-1:0];
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_exec_op(opcode_e'(opcode))) begin
                        exec_valid <= 1'b1;
                        state      <= S_EXEC;
                    end else if (opcode == OP_RETURN) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
`ifdef SEQ_ILLEGAL_TRAP_EN
                    end else if (opcode == OP_ILLEGAL) begin
                        illegal_op <= 1'b1;
                        halted     <= 1'b1;
                        state      <= S_HALT;
`endif
                    end else begin
                        // Control flow (and untrapped opcode 15) refetches from the new PC.
                        pc       <= npc;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        exec_valid <= 1'b0;
                        pc         <= npc;
                        imem_req   <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an ISA model predicts fetch addresses and executed words.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       imem_req;
    logic [9:0] imem_addr;
    logic       imem_ack;
    logic [9:0] imem_data;
    logic [3:0] opcode;
    logic [5:0] operand;
    logic       exec_valid;
    logic       exec_done;
    logic       flag;
    logic       halted;
    logic       illegal_op;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .opcode     (opcode),
        .operand    (operand),
        .exec_valid (exec_valid),
        .exec_done  (exec_done),
        .flag       (flag),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] mem [0:1023];
    logic [9:0] exp_fetch [$];
    logic [9:0] exp_exec  [$];
    int         n_exec;
    logic       exp_ill;

    int   ack_delay  = 0;
    int   exec_delay = 0;
    bit   force_done = 1'b0;
    int   ex_cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Memory and datapath responder, plus scoreboard pops, all on the falling edge.
    initial begin
        int         fw;
        int         ew;
        logic [9:0] addr0;
        imem_ack = 1'b0; imem_data = '0; exec_done = 1'b0;
        fw = 0; ew = 0; addr0 = '0;
        forever begin
            @(negedge clk);
            if (imem_req && rst_n) begin
                if (fw == 0) addr0 = imem_addr;
                else chk("addr_stable", imem_addr, addr0);
                if (fw >= ack_delay) begin
                    if (exp_fetch.size() == 0) chk("fetch_extra", 1, 0);
                    else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
                    imem_data = mem[imem_addr];
                    imem_ack  = 1'b1;
                    fw = 0;
                end else begin
                    imem_ack = 1'b0;
                    fw++;
                end
            end else begin
                imem_ack = 1'b0;
                fw = 0;
            end
            if (exec_valid && rst_n) begin
                ex_cyc++;
                if (ew == 0) begin
                    if (exp_exec.size() == 0) chk("exec_extra", 1, 0);
                    else chk("exec_word", {opcode, operand}, exp_exec.pop_front());
                end
                if (ew >= exec_delay) begin
                    exec_done = 1'b1;
                    ew = 0;
                end else begin
                    exec_done = force_done;
                    ew++;
                end
            end else begin
                exec_done = force_done;
                ew = 0;
            end
        end
    end

    task automatic build_model(input logic fl);
        logic [9:0] pc;
        logic [3:0] op;
        logic [5:0] opd;
        bit         done;
        exp_fetch.delete();
        exp_exec.delete();
        n_exec = 0; exp_ill = 1'b0; pc = '0; done = 1'b0;
        for (int s = 0; s < 64 && !done; s++) begin
            exp_fetch.push_back(pc);
            op  = mem[pc][9:6];
            opd = mem[pc][5:0];
            case (op)
                4'd4:  pc = pc - {4'b0, opd};
                4'd9:  pc = pc + {4'b0, opd};
                4'd10: pc = flag ? pc + 10'd1 : pc + 10'd2;
                4'd14: done = 1'b1;
                4'd15: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                    exp_ill = 1'b1;
                    done    = 1'b1;
`else
                    pc = pc + 10'd1;
`endif
                end
                default: begin
                    exp_exec.push_back(mem[pc]);
                    n_exec++;
                    pc = pc + 10'd1;
                end
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_ev", exec_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ill", illegal_op, 0);
        chk("rst_word", {opcode, operand}, 0);
        chk("rst_addr", imem_addr, 0);
        rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 10'h380;
    endtask

    task automatic run_prog(input logic fl, input int ad, input int ed);
        int to;
        flag = fl; ack_delay = ad; exec_delay = ed;
        build_model(fl);
        do_reset();
        ex_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 1;
        for (int c = 0; c < 2000; c++) begin
            if (halted) begin to = 0; break; end
            @(negedge clk);
        end
        chk("halt_timeout", to, 0);
        chk("fetch_left", exp_fetch.size(), 0);
        chk("exec_left", exp_exec.size(), 0);
        chk("halted", halted, 1);
        chk("illegal", illegal_op, exp_ill);
        chk("req_in_halt", imem_req, 0);
        chk("ev_in_halt", exec_valid, 0);
        chk("exec_cycles", ex_cyc, n_exec * (ed + 1));
    endtask

    initial begin
        int to;
        rst_n = 1'b0; start = 1'b0; flag = 1'b0;
        clear_mem();
        #1;
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_halted", halted, 0);

        // setImmediate then return
        mem[0] = 10'h040; mem[1] = 10'h380;
        run_prog(1'b0, 0, 0);
        chk("halt_pc", imem_addr, 1);
        run_prog(1'b0, 1, 2);
        run_prog(1'b0, 4, 0);

        // start is ignored once halted
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt_sticky", halted, 1);
        chk("halt_no_req", imem_req, 0);

        // wrap in both directions: 0 -> 5 -> 1022 -> 1
        clear_mem();
        mem[0] = {4'd9, 6'd5}; mem[5] = {4'd4, 6'd7};
        mem[1022] = {4'd9, 6'd3}; mem[1] = 10'h380;
        run_prog(1'b0, 0, 0);
        chk("wrap_pc", imem_addr, 1);

        // skipIfNotOne at PC 10
        clear_mem();
        mem[0] = {4'd9, 6'd10}; mem[10] = {4'd10, 6'd0};
        mem[11] = 10'h380; mem[12] = {4'd5, 6'd1}; mem[13] = 10'h380;
        run_prog(1'b0, 0, 0);
        chk("skip_f0_pc", imem_addr, 13);
        run_prog(1'b1, 0, 1);
        chk("skip_f1_pc", imem_addr, 11);

        // opcode 15 at PC 3
        clear_mem();
        mem[0] = {4'd1, 6'd2}; mem[1] = {4'd2, 6'd3}; mem[2] = {4'd3, 6'd4};
        mem[3] = {4'd15, 6'd0}; mem[4] = 10'h380;
        run_prog(1'b0, 0, 0);
`ifdef SEQ_ILLEGAL_TRAP_EN
        chk("trap_pc", imem_addr, 3);
`else
        chk("nop_pc", imem_addr, 4);
`endif

        // reset while waiting on exec_done
        clear_mem();
        mem[0] = 10'h040;
        flag = 1'b0; ack_delay = 0; exec_delay = 1000;
        build_model(1'b0);
        do_reset();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        to = 1;
        for (int c = 0; c < 20; c++) begin
            if (exec_valid) begin to = 0; break; end
            @(negedge clk);
        end
        chk("ev_timeout", to, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midexec_ev", exec_valid, 0);
        chk("midexec_req", imem_req, 0);
        exp_fetch.delete(); exp_exec.delete();
        @(negedge clk); force_done = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_ignored_ev", exec_valid, 0);
        chk("done_ignored_req", imem_req, 0);
        force_done = 1'b0;

        // reset while waiting on imem_ack
        ack_delay = 1000; exec_delay = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midfetch_req_hi", imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midfetch_req", imem_req, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midfetch_idle", imem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  begin execution at PC 0 when sequencer is IDLE.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request, held until acknowledged.
REQ-005 SHALL have port imem_addr  output  10  fetch address, equal to PC.
REQ-006 SHALL have port imem_ack  input  1  fetch acknowledge; imem_data valid same cycle.
REQ-007 SHALL have port imem_data  input  10  instruction word: opcode [9:6], operand [5:0].
REQ-008 SHALL have port opcode  output  4  latched opcode of the current instruction, to decode control.
REQ-009 SHALL have port operand  output  6  latched operand of the current instruction.
REQ-010 SHALL have port exec_valid  output  1  datapath execute request, held until exec_done.
REQ-011 SHALL have port exec_done  input  1  datapath completion acknowledge.
REQ-012 SHALL have port flag  input  1  datapath condition bit (Bit0) sampled by skipIfNotOne.
REQ-013 SHALL have port halted  output  1  high while in HALT.
REQ-014 SHALL have port illegal_op  output  1  sticky illegal-opcode indication.

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-016 IDLE: on start=1 SHALL set PC=0 and go to FETCH next cycle; start ignored in every other state.
REQ-017 FETCH: SHALL assert imem_req with imem_addr=PC; on imem_ack=1 SHALL latch imem_data into opcode/operand, go DECODE; imem_ack outside FETCH ignored.
REQ-018 DECODE (one cycle): opcodes 0-3, 5-8, 11-13 SHALL go EXEC; control-flow opcodes SHALL update PC and go FETCH (or HALT) without exec_valid.
REQ-019 Opcode 4 jumpBackOrInit SHALL set PC = PC - operand; opcode 9 jumpOrInitFp SHALL set PC = PC + operand.
REQ-020 Opcode 10 skipIfNotOne SHALL set PC = PC + 2 when flag=0, else PC + 1; flag sampled in DECODE.
REQ-021 Opcode 14 return SHALL go HALT with PC unchanged.
REQ-022 EXEC: exec_valid SHALL be high from EXEC entry until the cycle exec_done=1; then PC = PC + 1, go FETCH; exec_done outside EXEC ignored.
REQ-023 All PC arithmetic SHALL be 10-bit modulo 1024 (1023+1 -> 0; 0-5 -> 1019).
REQ-024 HALT SHALL be left only by reset; halted=1 there; imem_req and exec_valid SHALL be 0.
REQ-025 Minimum latency for an executed instruction SHALL be 3 cycles (FETCH, DECODE, EXEC) with zero-wait ack/done.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, PC=0, opcode=0, operand=0, imem_req=0, exec_valid=0, halted=0, illegal_op=0, including mid-fetch or mid-execute.
REQ-027 First state change after rst_n release SHALL occur no earlier than the first rising clk edge with rst_n=1.

Configuration
REQ-028 Macro SEQ_ILLEGAL_TRAP_EN defined: opcode 15 in DECODE SHALL set illegal_op=1 and go HALT.
REQ-029 SEQ_ILLEGAL_TRAP_EN undefined: opcode 15 SHALL act as NOP (PC+1, go FETCH, no exec_valid) and illegal_op SHALL be tied 0.

Structure
REQ-030 Shared package seq_pkg SHALL hold opcode enumeration (0 result .. 14 return, 15 illegal), state enumeration, PC width 10, operand width 6.
REQ-031 Next-PC computation SHALL be a combinational sub-module seq_next_pc (inputs PC, opcode, operand, flag; output next PC).

Verification
REQ-032 Reset, start=1, program [0x040 setImmediate, 0x380 return], zero-wait ack/done -> exec_valid one cycle for PC 0, then HALT at PC 1, halted=1.
REQ-033 imem_ack delayed 4 cycles at PC 0 -> imem_req held 4 cycles, imem_addr=0 stable, no DECODE until ack.
REQ-034 PC=5 executing opcode 4 operand 7 -> next imem_addr=1022 (wrap); opcode 9 operand 3 at PC 1022 -> imem_addr=1.
REQ-035 skipIfNotOne at PC 10 with flag=0 -> next imem_addr=12; with flag=1 -> 11.
REQ-036 rst_n asserted while exec_valid=1 awaiting exec_done -> exec_valid=0 asynchronously, state IDLE, later exec_done ignored.
REQ-037 Opcode 15 at PC 3 -> with SEQ_ILLEGAL_TRAP_EN: illegal_op=1, halted=1; without: imem_addr=4, illegal_op=0.
